// File: rtl/cavlc_rbsp_feeder.sv
// cavlc_rbsp_feeder: packs 32-bit RBSP words into a left-justified bit buffer and exposes a 16-bit look-ahead window
module cavlc_rbsp_feeder #(
  parameter int WORD_W  = 32,
  parameter int BUF_W   = 64,
  parameter int MAX_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_W-1:0]            word_in,
  input  logic                         word_valid,
  output logic                         word_ready,
  input  logic                         flush,
  input  logic                         idle,
  input  logic [4:0]                   len_comb,
  output logic [0:MAX_LEN-1]           rbsp,
  output logic                         ena,
  output logic [$clog2(BUF_W+1)-1:0]   bit_count,
  output logic [31:0]                  bits_used,
  output logic                         err
);
  localparam int CW = $clog2(BUF_W+1);
  logic [BUF_W-1:0] r_buf;
  logic [CW-1:0]    r_count;
  logic [31:0]      r_used;
  logic             r_err;
  logic [CW-1:0]    w_len, w_lim, w_c, w_rem, w_sh;
  logic [BUF_W-1:0] w_word;
  logic             w_acc, w_take, w_err;
  assign ena        = r_count >= CW'(MAX_LEN);
  assign word_ready = !flush && (r_count <= CW'(BUF_W-WORD_W));
  assign rbsp       = r_buf[BUF_W-1 -: MAX_LEN];
  assign bit_count  = r_count;
  assign bits_used  = r_used;
  assign err        = r_err;
  assign w_acc      = word_valid && word_ready;
  assign w_take     = ena && !idle;
  assign w_len      = CW'(len_comb);
  // clamp consumption to what the window and buffer can actually supply, and place the new word right after the survivors
  always_comb begin
    w_lim  = (r_count < CW'(MAX_LEN)) ? r_count : CW'(MAX_LEN);
    w_c    = !w_take ? '0 : (w_len > w_lim) ? w_lim : w_len;
    w_err  = w_take && (len_comb != '0) && ((w_len > CW'(MAX_LEN)) || (w_len > r_count));
    w_rem  = r_count - w_c;
    w_sh   = CW'(BUF_W-WORD_W) - w_rem;
    w_word = {{(BUF_W-WORD_W){1'b0}}, word_in} << w_sh;
  end
  // buffer, fill level, consumed-bit total and sticky error; flush overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_count <= '0;
      r_used  <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_buf   <= '0;
      r_count <= '0;
      r_used  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_buf   <= (r_buf << w_c) | (w_acc ? w_word : '0);
      r_count <= w_rem + (w_acc ? CW'(WORD_W) : '0);
      r_used  <= r_used + 32'(w_c);
      r_err   <= r_err | w_err;
    end
  end
endmodule

// File: tb/tb_cavlc_rbsp_feeder.sv
// tb_cavlc_rbsp_feeder: bit-queue scoreboard bench for the RBSP feeder
module tb_cavlc_rbsp_feeder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] word_in;
  logic        word_valid, word_ready, flush, idle, ena, err;
  logic [4:0]  len_comb;
  logic [0:15] rbsp;
  logic [6:0]  bit_count;
  logic [31:0] bits_used;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          m_q[$];
  logic [31:0] m_used;
  logic        m_err;
  logic [31:0] sum_c;
  cavlc_rbsp_feeder dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .flush(flush), .idle(idle), .len_comb(len_comb),
    .rbsp(rbsp), .ena(ena), .bit_count(bit_count), .bits_used(bits_used), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  // drive one cycle at posedge+1, compare against the model at the negedge, update the model, return at next posedge+1
  task automatic cyc(input logic v, input logic [31:0] w, input logic fl, input logic id, input logic [4:0] len, output logic acc);
    logic [15:0] win;
    logic        rdy, en, take;
    int          c, sz;
    word_valid = v; word_in = w; flush = fl; idle = id; len_comb = len;
    #4;
    sz  = m_q.size();
    rdy = !fl && sz <= 32;
    en  = sz >= 16;
    for (int i = 0; i < 16; i++) win[15-i] = (i < sz) ? m_q[i] : 1'b0;
    chk("ready", word_ready, rdy);
    chk("ena", ena, en);
    chk("count", bit_count, sz);
    chk("rbsp", rbsp, win);
    chk("used", bits_used, m_used);
    chk("err", err, m_err);
    acc = v && rdy;
    if (fl) begin
      m_q.delete(); m_used = 0; m_err = 0; sum_c = 0;
    end else begin
      take = en && !id;
      if (take && len != 0 && (len > 16 || int'(len) > sz)) m_err = 1;
      c = take ? ((len > 16) ? 16 : int'(len)) : 0;
      if (c > sz) c = sz;
      repeat (c) void'(m_q.pop_front());
      m_used += 32'(c);
      sum_c  += 32'(c);
      if (acc) for (int i = 31; i >= 0; i--) m_q.push_back(w[i]);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    logic        a, v;
    logic [31:0] pend;
    int          sent, cycles;
    m_used = 0; m_err = 0; sum_c = 0;
    rst_n = 1'b0; word_valid = 0; word_in = 0; flush = 0; idle = 1; len_comb = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", bit_count, 0);
    chk("rst_rbsp", rbsp, 0);
    chk("rst_ena", ena, 0);
    chk("rst_ready", word_ready, 1);
    rst_n = 1'b1;
    cyc(1, 32'hA5A5_0000, 0, 1, 0, a);
    chk("t1_rbsp", rbsp, 16'hA5A5);
    chk("t1_count", bit_count, 32);
    chk("t1_ena", ena, 1);
    chk("t1_ready", word_ready, 1);
    cyc(0, 0, 1, 1, 0, a);
    cyc(1, 32'hFFFF_0000, 0, 1, 0, a);
    cyc(1, 32'h1234_5678, 0, 0, 3, a);
    chk("t2_count", bit_count, 61);
    chk("t2_rbsp", rbsp, 16'hFFF8);
    chk("t2_used", bits_used, 3);
    cyc(0, 0, 1, 1, 0, a);
    cyc(1, 32'hDEAD_BEEF, 0, 1, 0, a);
    cyc(1, 32'hC0FF_EE11, 0, 0, 16, a);
    chk("t3_count48", bit_count, 48);
    repeat (4) begin
      cyc(1, 32'h0BAD_F00D, 0, 1, 0, a);
      chk("t3_full_ready", word_ready, 0);
    end
    cyc(1, 32'h0BAD_F00D, 0, 0, 16, a);
    cyc(1, 32'h0BAD_F00D, 0, 1, 0, a);
    chk("t3_count64", bit_count, 64);
    repeat (4) cyc(0, 0, 0, 0, 16, a);
    cyc(0, 0, 1, 1, 0, a);
    cyc(1, 32'h8765_4321, 0, 1, 0, a);
    cyc(0, 0, 0, 0, 12, a);
    chk("t4_count20", bit_count, 20);
    cyc(0, 0, 0, 0, 21, a);
    chk("t4_err", err, 1);
    chk("t4_count", bit_count, 4);
    chk("t4_ena", ena, 0);
    repeat (2) cyc(0, 0, 0, 0, 5, a);
    chk("t4_sticky", err, 1);
    cyc(1, 32'h5555_AAAA, 0, 0, 0, a);
    cyc(1, 32'h3333_CCCC, 1, 0, 4, a);
    chk("t5_count", bit_count, 0);
    chk("t5_rbsp", rbsp, 0);
    chk("t5_ena", ena, 0);
    chk("t5_used", bits_used, 0);
    chk("t5_err", err, 0);
    sent = 0; cycles = 0; pend = $urandom;
    while (sent < 10000 && cycles < 90000) begin
      v = ($urandom_range(0, 3) != 0);
      cyc(v, pend, 0, ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 16)), a);
      if (a) begin sent++; pend = $urandom; end
      cycles++;
    end
    chk("stream_sent", sent, 10000);
    for (int i = 0; i < 100 && m_q.size() >= 16; i++) cyc(0, 0, 0, 0, 16, a);
    chk("drain_ena", ena, 0);
    chk("used_total", bits_used, sum_c);
    chk("stream_err", err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
